// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared constants for the 8259 host bus master
package pic_pkg;

    localparam int CNT_W = 4;

    localparam logic STROBE_ACTIVE = 1'b0;
    localparam logic STROBE_IDLE   = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_SETUP    = 3'd1;
    localparam state_t ST_STROBE   = 3'd2;
    localparam state_t ST_HOLD     = 3'd3;
    localparam state_t ST_INTA1    = 3'd4;
    localparam state_t ST_INTA_GAP = 3'd5;
    localparam state_t ST_INTA2    = 3'd6;
    localparam state_t ST_RECOVER  = 3'd7;

endpackage

// File: rtl/pic_host_bus_master_if.sv
// rtl/pic_host_bus_master_if.sv - host command stream plus 8259 bus signals
interface pic_host_bus_master_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_a0;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       int_en;
    logic       int_in;
    logic       vec_valid;
    logic [7:0] vec_data;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       inta_n;
    logic       a0;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] d_in;

    modport master (
        input  cmd_valid, cmd_write, cmd_a0, cmd_wdata, int_en, int_in, d_in,
        output cmd_ready, rsp_valid, rsp_rdata, vec_valid, vec_data,
        output cs_n, wr_n, rd_n, inta_n, a0, d_out, d_oe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_a0, cmd_wdata, int_en, int_in, d_in,
        input  cmd_ready, rsp_valid, rsp_rdata, vec_valid, vec_data,
        input  cs_n, wr_n, rd_n, inta_n, a0, d_out, d_oe
    );

endinterface

// File: rtl/pic_sync2.sv
// rtl/pic_sync2.sv - two-flop synchroniser for asynchronous PIC inputs
module pic_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pic_host_bus_master.sv
// rtl/pic_host_bus_master.sv - turns host commands and INT into timed 8259 bus cycles
module pic_host_bus_master
    import pic_pkg::*;
#(
    parameter int PULSE_CYCLES   = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    pic_host_bus_master_if.master bus
);

    localparam logic [CNT_W-1:0] C_PULSE   = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] C_GAP     = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] C_RECOVER = CNT_W'(RECOVER_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write;
    logic             r_armed;
    logic             r_cs_n;
    logic             r_wr_n;
    logic             r_rd_n;
    logic             r_inta_n;
    logic             r_a0;
    logic [7:0]       r_d_out;
    logic             r_d_oe;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_rdata;
    logic             r_vec_valid;
    logic [7:0]       r_vec_data;

    logic w_int_s;
    logic w_take_int;
    logic w_cnt_done;

    pic_sync2 u_int_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.int_in),
        .o_q (w_int_s)
    );

    assign w_take_int = bus.int_en && w_int_s && r_armed;
    assign w_cnt_done = (r_cnt == C_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_armed     <= 1'b1;
            r_cs_n      <= STROBE_IDLE;
            r_wr_n      <= STROBE_IDLE;
            r_rd_n      <= STROBE_IDLE;
            r_inta_n    <= STROBE_IDLE;
            r_a0        <= 1'b0;
            r_d_out     <= 8'h00;
            r_d_oe      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_vec_valid <= 1'b0;
            r_vec_data  <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            r_vec_valid <= 1'b0;
            // A low int_s proves the previous INT was withdrawn, so a new one may be taken.
            if (!w_int_s) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_take_int) begin
                        r_state  <= ST_INTA1;
                        r_inta_n <= STROBE_ACTIVE;
                        r_cnt    <= C_PULSE;
                    end else if (bus.cmd_valid) begin
                        r_state <= ST_SETUP;
                        r_write <= bus.cmd_write;
                        r_cs_n  <= STROBE_ACTIVE;
                        r_a0    <= bus.cmd_a0;
                        r_d_oe  <= bus.cmd_write;
                        if (bus.cmd_write) begin
                            r_d_out <= bus.cmd_wdata;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_cnt   <= C_PULSE;
                    if (r_write) begin
                        r_wr_n <= STROBE_ACTIVE;
                    end else begin
                        r_rd_n <= STROBE_ACTIVE;
                    end
                end
                ST_STROBE: begin
                    if (w_cnt_done) begin
                        r_state <= ST_HOLD;
                        r_wr_n  <= STROBE_IDLE;
                        r_rd_n  <= STROBE_IDLE;
                        if (!r_write) begin
                            r_rsp_rdata <= bus.d_in;
                            r_rsp_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_HOLD: begin
                    r_cs_n  <= STROBE_IDLE;
                    r_d_oe  <= 1'b0;
                    r_cnt   <= C_RECOVER;
                    r_state <= (RECOVER_CYCLES == 0) ? ST_IDLE : ST_RECOVER;
                end
                ST_INTA1: begin
                    if (w_cnt_done) begin
                        r_state  <= ST_INTA_GAP;
                        r_inta_n <= STROBE_IDLE;
                        r_cnt    <= C_GAP;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_INTA_GAP: begin
                    if (w_cnt_done) begin
                        r_state  <= ST_INTA2;
                        r_inta_n <= STROBE_ACTIVE;
                        r_cnt    <= C_PULSE;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_INTA2: begin
                    if (w_cnt_done) begin
                        r_inta_n    <= STROBE_IDLE;
                        r_vec_data  <= bus.d_in;
                        r_vec_valid <= 1'b1;
                        if (w_int_s) begin
                            r_armed <= 1'b0;
                        end
                        r_cnt   <= C_RECOVER;
                        r_state <= (RECOVER_CYCLES == 0) ? ST_IDLE : ST_RECOVER;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_RECOVER: begin
                    if (w_cnt_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE) && !w_take_int;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.vec_valid = r_vec_valid;
    assign bus.vec_data  = r_vec_data;
    assign bus.cs_n      = r_cs_n;
    assign bus.wr_n      = r_wr_n;
    assign bus.rd_n      = r_rd_n;
    assign bus.inta_n    = r_inta_n;
    assign bus.a0        = r_a0;
    assign bus.d_out     = r_d_out;
    assign bus.d_oe      = r_d_oe;

endmodule

// File: tb/tb_pic_host_bus_master.sv
// tb/tb_pic_host_bus_master.sv - directed self-checking bench for pic_host_bus_master
module tb_pic_host_bus_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pic_host_bus_master_if bus ();

    pic_host_bus_master #(
        .PULSE_CYCLES   (2),
        .GAP_CYCLES     (2),
        .RECOVER_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // PIC model: odd INTA pulses return a junk byte, even ones the vector.
    logic [7:0] tb_din = 8'h00;
    logic [7:0] tb_vec = 8'h48;
    int         inta_edges = 0;

    always @(negedge bus.inta_n or posedge rst) begin
        if (rst) inta_edges = 0;
        else     inta_edges = inta_edges + 1;
    end

    assign bus.d_in = bus.inta_n ? tb_din : ((inta_edges % 2 == 0) ? tb_vec : 8'hEE);

    always @(negedge clk) begin
        if (!rst) begin
            assert ((int'(!bus.wr_n) + int'(!bus.rd_n) + int'(!bus.inta_n)) <= 1)
            else begin
                errors++;
                $display("FAIL strobe_overlap wr_n=%b rd_n=%b inta_n=%b required at most one low",
                         bus.wr_n, bus.rd_n, bus.inta_n);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    logic       exp_a0;
    logic [7:0] exp_wdata;
    int cs_low, wr_low, rd_low, doe_cnt, dout_bad, a0_bad;
    int pulses, w1, w2, gap, rsp_cnt, vec_cnt;
    int rsp_last, vec_last, cs_first, vec_first, ready_first;

    task automatic observe(input int n);
        logic prev_inta;
        int   run;
        cs_low = 0; wr_low = 0; rd_low = 0; doe_cnt = 0; dout_bad = 0; a0_bad = 0;
        pulses = 0; w1 = 0; w2 = 0; gap = 0; rsp_cnt = 0; vec_cnt = 0;
        rsp_last = -1; vec_last = -1; cs_first = -1; vec_first = -1; ready_first = -1;
        prev_inta = 1'b1;
        run = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!bus.cs_n) begin
                cs_low++;
                if (cs_first < 0) cs_first = i;
                if (bus.a0 !== exp_a0) a0_bad++;
            end
            if (!bus.wr_n) wr_low++;
            if (!bus.rd_n) rd_low++;
            if (bus.d_oe) begin
                doe_cnt++;
                if (bus.d_out !== exp_wdata || bus.cs_n) dout_bad++;
            end
            if (!bus.inta_n) begin
                if (prev_inta) pulses++;
                run++;
            end else begin
                if (!prev_inta) begin
                    if (pulses == 1) w1 = run;
                    else if (pulses == 2) w2 = run;
                    run = 0;
                end
                if (pulses == 1) gap++;
            end
            prev_inta = bus.inta_n;
            if (bus.rsp_valid) begin
                rsp_cnt++;
                rsp_last = int'(bus.rsp_rdata);
            end
            if (bus.vec_valid) begin
                vec_cnt++;
                vec_last = int'(bus.vec_data);
                if (vec_first < 0) vec_first = i;
            end
            if (bus.cmd_ready && ready_first < 0) ready_first = i;
            if (bus.cmd_valid && bus.cmd_ready) begin
                @(posedge clk);
                #1 bus.cmd_valid = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic       write;
        logic       a0;
        logic [7:0] wdata;
        logic [7:0] din;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int start_edges;
        bit hit;

        tbl[0] = '{write: 1'b1, a0: 1'b0, wdata: 8'h13, din: 8'h00};
        tbl[1] = '{write: 1'b0, a0: 1'b1, wdata: 8'h00, din: 8'hA5};
        tbl[2] = '{write: 1'b1, a0: 1'b1, wdata: 8'hFF, din: 8'h77};
        tbl[3] = '{write: 1'b0, a0: 1'b0, wdata: 8'h00, din: 8'h3C};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_a0    = 1'b0;
        bus.cmd_wdata = 8'h00;
        bus.int_en    = 1'b1;
        bus.int_in    = 1'b0;
        exp_a0        = 1'b0;
        exp_wdata     = 8'h00;

        repeat (3) @(negedge clk);
        chk("reset_strobes", int'({bus.cs_n, bus.wr_n, bus.rd_n, bus.inta_n,
                                   bus.a0, bus.d_oe, bus.rsp_valid, bus.vec_valid}), 8'b1111_0000);
        chk("reset_d_out", int'(bus.d_out), 0);
        chk("reset_rsp_rdata", int'(bus.rsp_rdata), 0);
        chk("reset_vec_data", int'(bus.vec_data), 0);
        chk("reset_cmd_ready", int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            bus.cmd_write = tbl[k].write;
            bus.cmd_a0    = tbl[k].a0;
            bus.cmd_wdata = tbl[k].wdata;
            tb_din        = tbl[k].din;
            exp_a0        = tbl[k].a0;
            exp_wdata     = tbl[k].wdata;
            bus.cmd_valid = 1'b1;
            observe(12);
            chk($sformatf("cmd%0d_cs_low", k), cs_low, 4);
            chk($sformatf("cmd%0d_wr_low", k), wr_low, tbl[k].write ? 2 : 0);
            chk($sformatf("cmd%0d_rd_low", k), rd_low, tbl[k].write ? 0 : 2);
            chk($sformatf("cmd%0d_d_oe_cycles", k), doe_cnt, tbl[k].write ? 4 : 0);
            chk($sformatf("cmd%0d_d_out_bad", k), dout_bad, 0);
            chk($sformatf("cmd%0d_a0_bad", k), a0_bad, 0);
            chk($sformatf("cmd%0d_rsp_count", k), rsp_cnt, tbl[k].write ? 0 : 1);
            if (!tbl[k].write) chk($sformatf("cmd%0d_rsp_rdata", k), rsp_last, int'(tbl[k].din));
            chk($sformatf("cmd%0d_accepted", k), int'(bus.cmd_valid), 0);
            chk($sformatf("cmd%0d_inta_pulses", k), pulses, 0);
        end

        tb_vec = 8'h48;
        @(posedge clk);
        #1 bus.int_in = 1'b1;
        observe(16);
        chk("ack_pulses", pulses, 2);
        chk("ack_width1", w1, 2);
        chk("ack_gap", gap, 2);
        chk("ack_width2", w2, 2);
        chk("ack_vec_count", vec_cnt, 1);
        chk("ack_vec_data", vec_last, 8'h48);
        chk("ack_cs_low", cs_low, 0);
        chk("ack_d_oe", doe_cnt, 0);

        observe(20);
        chk("stale_int_pulses", pulses, 0);
        chk("stale_int_vec", vec_cnt, 0);
        chk("stale_int_ready", int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1 bus.int_in = 1'b0;
        observe(4);
        tb_vec = 8'h49;
        @(posedge clk);
        #1 bus.int_in = 1'b1;
        observe(16);
        chk("reack_pulses", pulses, 2);
        chk("reack_vec_count", vec_cnt, 1);
        chk("reack_vec_data", vec_last, 8'h49);
        @(posedge clk);
        #1 bus.int_in = 1'b0;
        observe(4);

        // INT and a command arrive in the same IDLE cycle.
        tb_vec = 8'h50;
        @(posedge clk);
        #1 bus.int_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.cmd_write = 1'b1;
        bus.cmd_a0    = 1'b1;
        bus.cmd_wdata = 8'h5C;
        exp_a0        = 1'b1;
        exp_wdata     = 8'h5C;
        bus.cmd_valid = 1'b1;
        observe(25);
        chk("coll_vec_count", vec_cnt, 1);
        chk("coll_vec_data", vec_last, 8'h50);
        chk("coll_ready_after_vec", int'(ready_first > vec_first), 1);
        chk("coll_ready_idx", ready_first, 8);
        chk("coll_cs_after_vec", int'(cs_first > vec_first), 1);
        chk("coll_cs_low", cs_low, 4);
        chk("coll_wr_low", wr_low, 2);
        chk("coll_d_out_bad", dout_bad, 0);
        chk("coll_a0_bad", a0_bad, 0);
        chk("coll_accepted", int'(bus.cmd_valid), 0);
        @(posedge clk);
        #1 bus.int_in = 1'b0;
        observe(4);

        // Reset in the first cycle of the second INTA pulse.
        start_edges = inta_edges;
        @(posedge clk);
        #1 bus.int_in = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (!bus.inta_n && inta_edges == start_edges + 2) hit = 1'b1;
        end
        chk("rst_reached_inta2", int'(hit), 1);
        rst = 1'b1;
        #1;
        chk("rst_inta_n", int'(bus.inta_n), 1);
        chk("rst_cs_n", int'(bus.cs_n), 1);
        chk("rst_vec_valid", int'(bus.vec_valid), 0);
        chk("rst_idle_ready", int'(bus.cmd_ready), 1);
        bus.int_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        observe(10);
        chk("rst_no_vector", vec_cnt, 0);
        chk("rst_no_pulses", pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pic_host_bus_master.md
Name: pic_host_bus_master

Overview:
- CPU-side counterpart of the 8259 PIC: the initiator that the PIC's bus interface and INTA logic respond to.
- Converts a simple valid/ready command stream into timed 8259 bus cycles:
  - ICW/OCW writes with CS/WR/A0/D;
  - status reads with CS/RD/A0;
  - the two-pulse INTA acknowledge sequence when INT is raised, returning the captured vector byte.
- Sits between a host sequencer/testbench driver and the PIC top; a wrapper resolves d_out/d_oe/d_in onto the PIC's bidirectional D bus.

Parameters:
- PULSE_CYCLES, 2: width in clk cycles of each active-low strobe (wr_n, rd_n, inta_n); legal range 1..15.
- GAP_CYCLES, 2: cycles inta_n is high between the first and second INTA pulse; legal range 1..15.
- RECOVER_CYCLES, 1: idle cycles after any transaction before the next one starts; legal range 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  host command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write cycle, 0=read cycle
- cmd_a0  in  1  A0 value for the cycle
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: read data valid
- rsp_rdata  out  8  captured read data
- int_en  in  1  1=automatically acknowledge INT
- int_in  in  1  PIC INT output (asynchronous)
- vec_valid  out  1  one-cycle pulse: vector captured
- vec_data  out  8  vector byte from second INTA
- cs_n  out  1  chip select, active-low
- wr_n, rd_n, inta_n  out  1 each  bus strobes, active-low
- a0  out  1  address bit
- d_out  out  8  data driven to PIC
- d_oe  out  1  d_out drive enable
- d_in  in  8  data from PIC

Behaviour:
- Reset values:
  - cs_n, wr_n, rd_n, inta_n = 1;
  - a0 = 0, d_out = 0, d_oe = 0;
  - rsp_valid = 0, vec_valid = 0;
  - rsp_rdata = 0, vec_data = 0;
  - state = IDLE, armed = 1.
- INT synchronisation: int_in passes through a 2-FF synchroniser giving int_s (2-cycle latency).
- States: IDLE, SETUP, STROBE, HOLD, INTA1, INTA_GAP, INTA2, RECOVER.
- IDLE arbitration:
  - take_int = int_en && int_s && armed.
  - take_int has priority over commands.
  - cmd_ready = (state==IDLE) && !take_int (combinational).
- Write transaction:
  - Accept cycle → SETUP: cs_n=0, a0=cmd_a0, d_out=cmd_wdata, d_oe=1, wr_n=1.
  - STROBE: wr_n=0 for PULSE_CYCLES.
  - HOLD (1 cycle): wr_n=1; cs_n, a0, d_oe unchanged.
  - Then cs_n=1, d_oe=0 → RECOVER.
- Read transaction:
  - Same sequence with rd_n in place of wr_n and d_oe=0 throughout.
  - d_in is sampled on the last cycle of rd_n low.
  - rsp_rdata updated and rsp_valid pulses in the HOLD cycle.
- Acknowledge sequence:
  - cs_n stays 1 and d_oe stays 0 throughout.
  - INTA1: inta_n=0 for PULSE_CYCLES.
  - INTA_GAP: inta_n=1 for GAP_CYCLES.
  - INTA2: inta_n=0 for PULSE_CYCLES; d_in is sampled on its last cycle.
  - Next cycle: inta_n=1, vec_data updated, vec_valid pulses, armed cleared → RECOVER.
- Re-arm: armed is set whenever int_s==0; this prevents re-acknowledging a stale INT.
- RECOVER: all strobes high for RECOVER_CYCLES, then IDLE; 0 means go directly to IDLE.
- Interaction rules:
  - cmd_valid asserted during an acknowledge is held off (cmd_ready=0) and is never dropped.
  - int_en deasserting mid-sequence does not abort it.
  - An INT rising mid-command is serviced after RECOVER.
- At most one strobe is ever low; a bench assertion checks this.
- Single 4-bit down-counter: loaded on entry to each timed state, state advances when it reaches 1.
- rst mid-transaction returns all outputs immediately (asynchronously) to reset values.

Decomposition:
- Shared package pic_pkg:
  - state enum;
  - CNT_W=4;
  - strobe-level constants (STROBE_ACTIVE=0).
- One natural sub-module: pic_sync2 (2-FF synchroniser), reusable for the other asynchronous PIC inputs.

Test Plan:
- Write ICW1 cmd_a0=0, cmd_wdata=8'h13, PULSE_CYCLES=2 → cs_n low 4 cycles; wr_n low exactly 2 cycles; d_out=8'h13 with d_oe=1 from SETUP through HOLD; a0=0.
- Read with cmd_write=0, cmd_a0=1, d_in=8'hA5 → rd_n low 2 cycles; rsp_valid one pulse with rsp_rdata=8'hA5; d_oe never 1.
- int_en=1, int_in rises; PIC model returns 8'h48 on the second INTA → two inta_n pulses of 2 cycles separated by 2 high cycles; vec_valid once with vec_data=8'h48; cs_n stays 1.
- int_in held high after the vector → no second acknowledge until int_in goes low and rises again.
- cmd_valid and int_s rise in the same IDLE cycle → acknowledge first, cmd_ready=0 until after RECOVER, then the write completes with unchanged data.
- rst asserted during INTA2 → inta_n=1, vec_valid=0, state IDLE immediately; no vector emitted.
